// File: rtl/uart_frame_tx_if.sv
// Transmit-side bundle for uart_frame_tx: word handshake, baud divisor and serial status.
// Handshake: a word moves on the rising clock edge where tx_valid && tx_ready are both high;
// tx_ready is high only while the transmitter is idle, and tx_valid seen while tx_ready is
// low is ignored (no queuing). tx_data and dvsr only need to be stable at that edge.
interface uart_frame_tx_if #(
   parameter int DBIT   = 8,
   parameter int DVSR_W = 11
);
   logic [DVSR_W-1:0] dvsr;
   logic              tx_valid;
   logic              tx_ready;
   logic [DBIT-1:0]   tx_data;
   logic              tx;
   logic              tx_busy;
   logic              tx_done_tick;

   modport master (
      output dvsr, tx_valid, tx_data,
      input  tx_ready, tx, tx_busy, tx_done_tick
   );

   modport slave (
      input  dvsr, tx_valid, tx_data,
      output tx_ready, tx, tx_busy, tx_done_tick
   );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, DBIT data bits LSB first, optional parity, stop bits.
// Carries its own 16x baud-tick generator; the divisor is captured with the data word so a
// frame always runs at the rate it was accepted with.
module uart_frame_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int DVSR_W     = 11
) (
   input  logic               clk,
   input  logic               reset_n,
   uart_frame_tx_if.slave     bus,
   output logic [2:0]         o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   state_t              r_state;
   logic [DVSR_W-1:0]   r_baud_cnt;
   logic [TW-1:0]       r_tick_cnt;
   logic [BW-1:0]       r_bit_cnt;
   logic [DBIT-1:0]     r_shreg;
   logic [DVSR_W-1:0]   r_dvsr;
   logic                r_parity;
   logic                r_tx;

   state_t              w_state_next;
   logic [DVSR_W-1:0]   w_baud_next;
   logic [TW-1:0]       w_tick_next;
   logic [BW-1:0]       w_bit_next;
   logic [DBIT-1:0]     w_shreg_next;
   logic [DVSR_W-1:0]   w_dvsr_next;
   logic                w_parity_next;
   logic                w_tx_next;
   logic                w_done;
   logic                w_tick;

   // Reload value for the baud counter; divisors 0 and 1 both give a tick every clock.
   function automatic logic [DVSR_W-1:0] f_reload(input logic [DVSR_W-1:0] d);
      return (d == '0) ? '0 : d - DVSR_W'(1);
   endfunction

   // Baud tick fires when the down-counter reaches zero.
   assign w_tick = (r_baud_cnt == '0);

   // State register: everything resets so tx goes high the moment reset_n drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_dvsr     <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_next;
         r_tick_cnt <= w_tick_next;
         r_bit_cnt  <= w_bit_next;
         r_shreg    <= w_shreg_next;
         r_dvsr     <= w_dvsr_next;
         r_parity   <= w_parity_next;
         r_tx       <= w_tx_next;
      end
   end

   // Next-state, counters and the registered line value derived from the next state.
   always_comb begin
      w_state_next  = r_state;
      w_baud_next   = r_baud_cnt;
      w_tick_next   = r_tick_cnt;
      w_bit_next    = r_bit_cnt;
      w_shreg_next  = r_shreg;
      w_dvsr_next   = r_dvsr;
      w_parity_next = r_parity;
      w_done        = 1'b0;
      w_tx_next     = 1'b1;

      if (r_state != S_IDLE) begin
         w_baud_next = w_tick ? f_reload(r_dvsr) : (r_baud_cnt - DVSR_W'(1));
      end

      case (r_state)
         S_IDLE: begin
            if (bus.tx_valid) begin
               w_state_next  = S_START;
               w_dvsr_next   = bus.dvsr;
               w_baud_next   = f_reload(bus.dvsr);
               w_tick_next   = '0;
               w_bit_next    = '0;
               w_shreg_next  = bus.tx_data;
               w_parity_next = (^bus.tx_data) ^ 1'(PARITY_ODD);
            end
         end
         S_START: begin
            if (w_tick) begin
               if (r_tick_cnt == TW'(15)) begin
                  w_state_next = S_DATA;
                  w_tick_next  = '0;
                  w_bit_next   = '0;
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_tick_cnt == TW'(15)) begin
                  w_tick_next  = '0;
                  w_shreg_next = r_shreg >> 1;
                  if (r_bit_cnt == BW'(DBIT - 1)) begin
                     w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     w_bit_next = r_bit_cnt + BW'(1);
                  end
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               if (r_tick_cnt == TW'(15)) begin
                  w_state_next = S_STOP;
                  w_tick_next  = '0;
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_tick_cnt == TW'(SB_TICK - 1)) begin
                  w_state_next = S_IDLE;
                  w_tick_next  = '0;
                  w_done       = 1'b1;
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shreg_next[0];
         S_PARITY: w_tx_next = r_parity;
         default:  w_tx_next = 1'b1;
      endcase
   end

   assign bus.tx           = r_tx;
   assign bus.tx_busy      = (r_state != S_IDLE);
   assign bus.tx_ready     = (r_state == S_IDLE);
   assign bus.tx_done_tick = w_done;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: 8N1, 8E1 and 8O1 instances, hand-computed frames.
// A frame is captured as a bit vector: bit k is the line value at the middle of serial bit k
// (bit 0 = start, then data LSB first, then parity if present, then stop).
module tb_uart_frame_tx;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic reset_n;

   int n_total = 0;
   int n_bad   = 0;
   int n_done[3] = '{0, 0, 0};

   logic        tb_valid[3];
   logic [7:0]  tb_data[3];
   logic [10:0] tb_dvsr[3];
   logic [2:0]  dbg_n, dbg_e, dbg_o;

   always #5 if (clk_en) clk = ~clk;

   uart_frame_tx_if #(.DBIT(8), .DVSR_W(11)) if_n ();
   uart_frame_tx_if #(.DBIT(8), .DVSR_W(11)) if_e ();
   uart_frame_tx_if #(.DBIT(8), .DVSR_W(11)) if_o ();

   assign if_n.tx_valid = tb_valid[0];
   assign if_n.tx_data  = tb_data[0];
   assign if_n.dvsr     = tb_dvsr[0];
   assign if_e.tx_valid = tb_valid[1];
   assign if_e.tx_data  = tb_data[1];
   assign if_e.dvsr     = tb_dvsr[1];
   assign if_o.tx_valid = tb_valid[2];
   assign if_o.tx_data  = tb_data[2];
   assign if_o.dvsr     = tb_dvsr[2];

   uart_frame_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0), .DVSR_W(11)) u_8n1 (
      .clk(clk), .reset_n(reset_n), .bus(if_n), .o_dbg_state(dbg_n));
   uart_frame_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0), .DVSR_W(11)) u_8e1 (
      .clk(clk), .reset_n(reset_n), .bus(if_e), .o_dbg_state(dbg_e));
   uart_frame_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1), .DVSR_W(11)) u_8o1 (
      .clk(clk), .reset_n(reset_n), .bus(if_o), .o_dbg_state(dbg_o));

   function automatic logic get_tx(input int sel);
      case (sel)
         0: return if_n.tx;
         1: return if_e.tx;
         default: return if_o.tx;
      endcase
   endfunction

   function automatic logic get_ready(input int sel);
      case (sel)
         0: return if_n.tx_ready;
         1: return if_e.tx_ready;
         default: return if_o.tx_ready;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0: return if_n.tx_busy;
         1: return if_e.tx_busy;
         default: return if_o.tx_busy;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0: return if_n.tx_done_tick;
         1: return if_e.tx_done_tick;
         default: return if_o.tx_done_tick;
      endcase
   endfunction

   // Count done pulses away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (get_done(i)) n_done[i]++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single edge; data is scrambled afterwards to prove it was latched.
   task automatic start_xfer(input int sel, input logic [7:0] data, input logic [10:0] dv);
      tb_valid[sel] = 1'b1;
      tb_data[sel]  = data;
      tb_dvsr[sel]  = dv;
      step();
      tb_valid[sel] = 1'b0;
      tb_data[sel]  = ~data;
   endtask

   // Called in cycle 1 of a frame; returns in the first cycle after the done pulse.
   task automatic collect(input int sel, input int d, input int nbits,
                          output logic [15:0] obs, output int done_at, output int n_ready_hi);
      int budget;
      int k;
      budget     = nbits * 16 * d + 64;
      obs        = '0;
      done_at    = 0;
      n_ready_hi = 0;
      for (int c = 1; c <= budget; c++) begin
         if (c >= 8 * d && ((c - 8 * d) % (16 * d)) == 0) begin
            k = (c - 8 * d) / (16 * d);
            if (k < nbits) obs[k] = get_tx(sel);
         end
         if (get_ready(sel)) n_ready_hi++;
         if (get_done(sel) && done_at == 0) done_at = c;
         step();
         if (done_at != 0) break;
      end
   endtask

   task automatic run_frame(input int sel, input logic [7:0] data, input logic [10:0] dv,
                            input logic [10:0] dv_after, input int d_eff, input int nbits,
                            input logic [15:0] exp_frame, input string tag);
      logic [15:0] obs;
      int done_at, nr, p0;
      p0 = n_done[sel];
      check_eq({tag, "_rdy_before"}, 32'(get_ready(sel)), 32'd1);
      start_xfer(sel, data, dv);
      tb_dvsr[sel] = dv_after;
      check_eq({tag, "_busy_c1"}, 32'(get_busy(sel)), 32'd1);
      check_eq({tag, "_start_c1"}, 32'(get_tx(sel)), 32'd0);
      collect(sel, d_eff, nbits, obs, done_at, nr);
      check_eq({tag, "_frame"}, 32'(obs), 32'(exp_frame));
      check_eq({tag, "_done_at"}, done_at, nbits * 16 * d_eff);
      check_eq({tag, "_rdy_low"}, nr, 0);
      check_eq({tag, "_pulses"}, n_done[sel] - p0, 1);
      check_eq({tag, "_rdy_after"}, 32'(get_ready(sel)), 32'd1);
      check_eq({tag, "_idle_tx"}, 32'(get_tx(sel)), 32'd1);
   endtask

   initial begin
      logic [15:0] obs;
      int done_at, nr, p0;

      for (int i = 0; i < 3; i++) begin
         tb_valid[i] = 1'b0;
         tb_data[i]  = 8'h00;
         tb_dvsr[i]  = 11'd4;
      end

      // Reset with the clock stopped: outputs must settle asynchronously.
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #4;
      check_eq("rst_tx", 32'(if_n.tx), 32'd1);
      check_eq("rst_ready", 32'(if_n.tx_ready), 32'd1);
      check_eq("rst_busy", 32'(if_n.tx_busy), 32'd0);
      check_eq("rst_done", 32'(if_n.tx_done_tick), 32'd0);
      check_eq("rst_tx_par", 32'(if_e.tx), 32'd1);
      clk_en = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      step();

      // 8N1 0x55, dvsr=4: 160 ticks * 4 clocks.
      run_frame(0, 8'h55, 11'd4, 11'd4, 4, 10, 16'h02AA, "n55");

      // Parity frames, 176 ticks * 4 clocks.
      run_frame(1, 8'h07, 11'd4, 11'd4, 4, 11, 16'h060E, "e07");
      run_frame(2, 8'h07, 11'd4, 11'd4, 4, 11, 16'h040E, "o07");
      run_frame(1, 8'h00, 11'd4, 11'd4, 4, 11, 16'h0400, "e00");
      run_frame(2, 8'h00, 11'd4, 11'd4, 4, 11, 16'h0600, "o00");

      // tx_valid held across two frames.
      p0 = n_done[0];
      tb_valid[0] = 1'b1;
      tb_data[0]  = 8'hAA;
      tb_dvsr[0]  = 11'd4;
      step();
      tb_data[0] = 8'h0F;
      collect(0, 4, 10, obs, done_at, nr);
      check_eq("b2b_f1_frame", 32'(obs), 32'h354);
      check_eq("b2b_f1_done_at", done_at, 640);
      check_eq("b2b_f1_rdy_low", nr, 0);
      check_eq("b2b_gap_ready", 32'(if_n.tx_ready), 32'd1);
      check_eq("b2b_gap_tx", 32'(if_n.tx), 32'd1);
      step();
      tb_valid[0] = 1'b0;
      check_eq("b2b_f2_start", 32'(if_n.tx), 32'd0);
      check_eq("b2b_f2_busy", 32'(if_n.tx_busy), 32'd1);
      collect(0, 4, 10, obs, done_at, nr);
      check_eq("b2b_f2_frame", 32'(obs), 32'h21E);
      check_eq("b2b_f2_done_at", done_at, 640);
      check_eq("b2b_pulses", n_done[0] - p0, 2);

      // Reset in the middle of data bit 3 of 0xF0 (line low there).
      p0 = n_done[0];
      start_xfer(0, 8'hF0, 11'd4);
      repeat (4 * 64 + 9) step();
      check_eq("mid_pre_tx", 32'(if_n.tx), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check_eq("mid_rst_tx", 32'(if_n.tx), 32'd1);
      check_eq("mid_rst_ready", 32'(if_n.tx_ready), 32'd1);
      check_eq("mid_rst_busy", 32'(if_n.tx_busy), 32'd0);
      check_eq("mid_rst_done", 32'(if_n.tx_done_tick), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      step();
      step();
      check_eq("mid_post_ready", 32'(if_n.tx_ready), 32'd1);
      check_eq("mid_no_pulse", n_done[0] - p0, 0);
      run_frame(0, 8'h3C, 11'd4, 11'd4, 4, 10, 16'h0278, "n3c");

      // Divisor changed right after acceptance must not alter the frame.
      run_frame(0, 8'h55, 11'd40, 11'd10, 40, 10, 16'h02AA, "dv40");

      // Minimum divisors: 0 and 1 both tick every clock.
      run_frame(0, 8'hA5, 11'd1, 11'd1, 1, 10, 16'h034A, "dv1");
      run_frame(0, 8'hA5, 11'd0, 11'd0, 1, 10, 16'h034A, "dv0");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
